// File: rtl/mem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mem_responder_pkg
// Brief   : Shared encodings for the load/store memory responder.
// Revision: 1.0 - initial release
// ============================================================================
package mem_responder_pkg;

    localparam logic [1:0] c_SZ_BYTE    = 2'b00;
    localparam logic [1:0] c_SZ_HALF    = 2'b01;
    localparam logic [1:0] c_SZ_WORD    = 2'b10;
    localparam logic [1:0] c_SZ_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        c_ST_IDLE = 2'd0,
        c_ST_WAIT = 2'd1,
        c_ST_RESP = 2'd2
    } state_e;

    // Bit positions in the error-cause vector; err is the OR of all causes.
    localparam int c_ERR_W        = 3;
    localparam int c_ERR_MISALIGN = 0;
    localparam int c_ERR_SIZE     = 1;
    localparam int c_ERR_RANGE    = 2;

endpackage
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// ============================================================================
// Module  : mem_lane_align
// Brief   : Byte-lane enables, store-data replication and load-data shift.
// Revision: 1.0 - initial release
// ============================================================================
module mem_lane_align
    import mem_responder_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_word,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata_rep,
    output logic [31:0] o_rdata_shift,
    output logic        o_misalign
);

    always_comb begin
        o_be        = 4'b0000;
        o_wdata_rep = i_wdata;
        o_misalign  = 1'b0;
        case (i_size)
            c_SZ_BYTE: begin
                o_be        = 4'b0001 << i_addr_lo;
                o_wdata_rep = {4{i_wdata[7:0]}};
            end
            c_SZ_HALF: begin
                o_be        = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata_rep = {2{i_wdata[15:0]}};
                o_misalign  = i_addr_lo[0];
            end
            c_SZ_WORD: begin
                o_be       = 4'b1111;
                o_misalign = |i_addr_lo;
            end
            default: o_be = 4'b0000;
        endcase
    end

    // Addressed byte/half lands in the low bits for the core's extender.
    assign o_rdata_shift = i_word >> {i_addr_lo, 3'b000};

endmodule
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module  : mem_responder
// Brief   : Req/ack memory target with wait states, lane merging, error flags.
// Revision: 1.0 - initial release
// ============================================================================
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ack,
    output logic        err
);

    localparam int         c_IDX_W  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] c_LAT_M1 = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    state_e              r_state;
    logic [3:0]          r_cnt;
    logic                r_we;
    logic [1:0]          r_size;
    logic [31:0]         r_addr;
    logic [31:0]         r_wdata;
    logic [31:0]         r_mem [DEPTH_WORDS];

    logic                w_idle;
    logic                w_we;
    logic [1:0]          w_size;
    logic [31:0]         w_addr;
    logic [c_IDX_W-1:0]  w_idx;
    logic [3:0]          w_be;
    logic [31:0]         w_wdata_rep;
    logic [31:0]         w_rdata_shift;
    logic                w_misalign;
    logic [c_ERR_W-1:0]  w_err_cause;
    logic                w_err;
    logic                w_go_resp;
    logic                w_commit;

    // With zero latency RESP is entered on the accept edge itself, so the
    // checks must see the live request while idle and the latches otherwise.
    assign w_idle = (r_state == c_ST_IDLE);
    assign w_we   = w_idle ? we    : r_we;
    assign w_size = w_idle ? size  : r_size;
    assign w_addr = w_idle ? addr  : r_addr;
    assign w_idx  = w_addr[c_IDX_W+1:2];

    mem_lane_align u_lane_align (
        .i_size        (w_size),
        .i_addr_lo     (w_addr[1:0]),
        .i_wdata       (r_wdata),
        .i_word        (r_mem[w_idx]),
        .o_be          (w_be),
        .o_wdata_rep   (w_wdata_rep),
        .o_rdata_shift (w_rdata_shift),
        .o_misalign    (w_misalign)
    );

    assign w_err_cause[c_ERR_MISALIGN] = w_misalign;
    assign w_err_cause[c_ERR_SIZE]     = (w_size == c_SZ_ILLEGAL);
    assign w_err_cause[c_ERR_RANGE]    = ({2'b00, w_addr[31:2]} >= 32'(DEPTH_WORDS));
    assign w_err                       = |w_err_cause;

    assign w_go_resp = (w_idle && req && (LATENCY == 0)) ||
                       ((r_state == c_ST_WAIT) && (r_cnt == 4'd0));
    assign w_commit  = (r_state == c_ST_RESP) && r_we && !err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_size  <= 2'b00;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            ack     <= 1'b0;
            err     <= 1'b0;
            rdata   <= 32'd0;
        end else begin
            ack <= 1'b0;
            err <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (req) begin
                        r_we    <= we;
                        r_size  <= size;
                        r_addr  <= addr;
                        r_wdata <= wdata;
                        if (LATENCY > 0) begin
                            r_state <= c_ST_WAIT;
                            r_cnt   <= c_LAT_M1;
                        end
                    end
                end
                c_ST_WAIT: begin
                    if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
                end
                c_ST_RESP: r_state <= c_ST_IDLE;
                default:   r_state <= c_ST_IDLE;
            endcase
            if (w_go_resp) begin
                r_state <= c_ST_RESP;
                ack     <= 1'b1;
                err     <= w_err;
                if (w_err)      rdata <= 32'd0;
                else if (!w_we) rdata <= w_rdata_shift;
            end
        end
    end

    // Backing array is not reset; the write lands on the edge leaving RESP.
    always_ff @(posedge clk) begin
        if (w_commit) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wdata_rep[8*i +: 8];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_responder
// Brief   : Self-checking bench; two instances (LATENCY=0 and LATENCY=1).
// Revision: 1.0 - initial release
// ============================================================================
module tb_mem_responder;

    localparam int DEPTH = 1024;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [1:0]        req_v, we_v;
    logic [1:0][1:0]   size_v;
    logic [1:0][31:0]  addr_v, wdata_v;
    logic [31:0]       rdata_u [2];
    logic              ack_u   [2];
    logic              err_u   [2];

    int                tests = 0;
    int                fails = 0;
    logic [7:0]        mdl   [2][4*DEPTH];
    logic [31:0]       prevd [2];

    always #5 clk = ~clk;

    // Instance index equals its LATENCY.
    mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(0)) u_dut_l0 (
        .clk(clk), .rst_n(rst_n), .req(req_v[0]), .we(we_v[0]), .size(size_v[0]),
        .addr(addr_v[0]), .wdata(wdata_v[0]), .rdata(rdata_u[0]), .ack(ack_u[0]), .err(err_u[0])
    );
    mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) u_dut_l1 (
        .clk(clk), .rst_n(rst_n), .req(req_v[1]), .we(we_v[1]), .size(size_v[1]),
        .addr(addr_v[1]), .wdata(wdata_v[1]), .rdata(rdata_u[1]), .ack(ack_u[1]), .err(err_u[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mword(input int d, input logic [31:0] a);
        int b;
        b = int'({a[31:2], 2'b00});
        return {mdl[d][b+3], mdl[d][b+2], mdl[d][b+1], mdl[d][b]};
    endfunction

    task automatic txn(input int d, input bit w, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] wd, output logic [31:0] rd, output logic e, output int lat);
        @(negedge clk);
        req_v[d] = 1'b1; we_v[d] = w; size_v[d] = sz; addr_v[d] = a; wdata_v[d] = wd;
        lat = 0;
        while (lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (ack_u[d]) break;
        end
        rd = rdata_u[d];
        e  = err_u[d];
        req_v[d] = 1'b0;
        @(posedge clk); #1;
        check($sformatf("ack_pulse d%0d a%h", d, a), 32'(ack_u[d]), 32'h0);
    endtask

    // Byte-addressed reference: compute the expected outcome, then run and compare.
    task automatic run(input int d, input bit w, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] wd, output logic [31:0] rd, output logic e);
        logic        bad;
        logic [31:0] exp_rd;
        int          nb, lat;
        bad = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00) ||
              (a[31:2] >= 30'(DEPTH));
        nb  = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        if (bad) exp_rd = 32'd0;
        else if (w) begin
            for (int i = 0; i < nb; i++) mdl[d][int'(a) + i] = wd[8*i +: 8];
            exp_rd = prevd[d];
        end else exp_rd = mword(d, a) >> (8 * a[1:0]);
        prevd[d] = exp_rd;
        txn(d, w, sz, a, wd, rd, e, lat);
        check($sformatf("rdata d%0d we%0d sz%0d a%h", d, w, sz, a), rd, exp_rd);
        check($sformatf("err d%0d we%0d sz%0d a%h", d, w, sz, a), 32'(e), 32'(bad));
        check($sformatf("latency d%0d a%h", d, a), 32'(lat), 32'(d + 1));
    endtask

    initial begin
        logic [31:0] rd;
        logic        e;
        logic        ack_seen;
        logic [31:0] a;

        req_v = '0; we_v = '0; size_v = '0; addr_v = '0; wdata_v = '0;
        prevd[0] = 32'd0; prevd[1] = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("reset_ack d%0d", d), 32'(ack_u[d]), 32'h0);
            check($sformatf("reset_err d%0d", d), 32'(err_u[d]), 32'h0);
            check($sformatf("reset_rdata d%0d", d), rdata_u[d], 32'h0);
        end
        rst_n = 1'b1;

        // Fill a known window (words 0..23) in both instances.
        for (int d = 0; d < 2; d++)
            for (int wi = 0; wi < 24; wi++) run(d, 1'b1, 2'b10, 32'(wi * 4), $urandom, rd, e);

        run(1, 1'b1, 2'b10, 32'h10, 32'hDEADBEEF, rd, e);
        run(1, 1'b0, 2'b10, 32'h10, 32'h0, rd, e);
        check("word_roundtrip", rd, 32'hDEADBEEF);

        run(1, 1'b1, 2'b10, 32'h20, 32'h11223344, rd, e);
        run(1, 1'b1, 2'b00, 32'h21, 32'h000000AA, rd, e);
        run(1, 1'b0, 2'b10, 32'h20, 32'h0, rd, e);
        check("byte_merge_word", rd, 32'h1122AA44);
        run(1, 1'b0, 2'b00, 32'h23, 32'h0, rd, e);
        check("byte_load_top", rd, 32'h00000011);

        run(1, 1'b1, 2'b10, 32'h30, 32'h0, rd, e);
        run(1, 1'b1, 2'b01, 32'h32, 32'h0000BEEF, rd, e);
        run(1, 1'b0, 2'b10, 32'h30, 32'h0, rd, e);
        check("half_merge_word", rd, 32'hBEEF0000);
        run(1, 1'b0, 2'b01, 32'h32, 32'h0, rd, e);
        check("half_load_upper", rd, 32'h0000BEEF);

        run(1, 1'b1, 2'b10, 32'h40, 32'hCAFEF00D, rd, e);
        run(1, 1'b0, 2'b10, 32'h41, 32'h0, rd, e);
        check("misaligned_word_err", 32'(e), 32'h1);
        check("misaligned_word_rdata", rd, 32'h0);
        run(1, 1'b1, 2'b01, 32'h43, 32'h00001234, rd, e);
        check("misaligned_half_err", 32'(e), 32'h1);
        run(1, 1'b0, 2'b10, 32'h40, 32'h0, rd, e);
        check("no_write_on_err", rd, 32'hCAFEF00D);
        run(1, 1'b0, 2'b10, 32'(DEPTH * 4), 32'h0, rd, e);
        check("out_of_range_err", 32'(e), 32'h1);
        run(1, 1'b0, 2'b11, 32'h40, 32'h0, rd, e);
        check("illegal_size_err", 32'(e), 32'h1);

        // LATENCY=0 with req held across two loads: acks one edge apart from IDLE turnaround.
        @(negedge clk);
        req_v[0] = 1'b1; we_v[0] = 1'b0; size_v[0] = 2'b10; addr_v[0] = 32'h10;
        @(posedge clk); #1;
        check("b2b_ack1", 32'(ack_u[0]), 32'h1);
        check("b2b_rdata1", rdata_u[0], mword(0, 32'h10));
        addr_v[0] = 32'h20;
        @(posedge clk); #1;
        check("b2b_gap", 32'(ack_u[0]), 32'h0);
        @(posedge clk); #1;
        check("b2b_ack2", 32'(ack_u[0]), 32'h1);
        check("b2b_rdata2", rdata_u[0], mword(0, 32'h20));
        req_v[0] = 1'b0;
        prevd[0] = mword(0, 32'h20);
        @(posedge clk); #1;
        check("b2b_no_dup", 32'(ack_u[0]), 32'h0);

        // Reset while a store is waiting: abandoned, no ack, no write.
        run(1, 1'b1, 2'b10, 32'h50, 32'h12345678, rd, e);
        @(negedge clk);
        req_v[1] = 1'b1; we_v[1] = 1'b1; size_v[1] = 2'b10; addr_v[1] = 32'h50;
        wdata_v[1] = 32'hFFFFFFFF;
        @(posedge clk); #1;
        rst_n = 1'b0;
        req_v[1] = 1'b0;
        ack_seen = 1'b0;
        repeat (2) begin @(posedge clk); #1; ack_seen |= ack_u[1]; end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin @(posedge clk); #1; ack_seen |= ack_u[1]; end
        check("reset_mid_no_ack", 32'(ack_seen), 32'h0);
        check("reset_mid_rdata", rdata_u[1], 32'h0);
        prevd[0] = 32'd0; prevd[1] = 32'd0;
        run(1, 1'b0, 2'b10, 32'h50, 32'h0, rd, e);
        check("reset_mid_no_write", rd, 32'h12345678);

        for (int d = 0; d < 2; d++) begin
            for (int n = 0; n < 60; n++) begin
                a = 32'($urandom_range(0, 95));
                if ($urandom_range(0, 15) == 0) a = 32'(DEPTH * 4) + 32'($urandom_range(0, 4095));
                run(d, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), a, $urandom, rd, e);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
